// File: rtl/seq_divider_16x8.sv
// seq_divider_16x8: 16/8 unsigned restoring divider, one quotient bit per clock.
// Start/done/error handshake with a 3-bit state code for the display controller.
`default_nettype none

module seq_divider_16x8 (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient_out,
  output logic [7:0]  remainder_out,
  output logic        done_flag,
  output logic        err_flag,
  output logic        div_by_zero,
  output logic        busy,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CALC      = 3'b010,
    CALC_DONE = 3'b100,
    ERR       = 3'b101
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  iter;
  logic [15:0] work_q;
  logic [7:0]  work_r;
  logic [7:0]  dvsr;

  logic        accept;
  logic        step;
  logic [8:0]  trial;
  logic        qbit;
  logic [7:0]  next_r;
  logic [15:0] next_q;

  // Trial subtraction in 9 bits: bit 8 set means the partial remainder was below dvsr.
  always_comb begin
    trial  = {work_r, work_q[15]} - {1'b0, dvsr};
    qbit   = ~trial[8];
    next_r = qbit ? trial[7:0] : {work_r[6:0], work_q[15]};
    next_q = {work_q[14:0], qbit};
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE:      accept = start;
      CALC: begin
        if (start) begin
          state_next = ERR;
        end else begin
          step = 1'b1;
          if (iter == 4'd0) state_next = CALC_DONE;
        end
      end
      CALC_DONE: begin
        if (start) accept = 1'b1;
        else       state_next = IDLE;
      end
      ERR:       accept = start;
      default:   state_next = IDLE;
    endcase
    if (accept) state_next = (divisor == 8'd0) ? ERR : CALC;
  end

  always_ff @(posedge clk) begin
    if (reset_a) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      iter          <= 4'd0;
      work_q        <= 16'd0;
      work_r        <= 8'd0;
      dvsr          <= 8'd0;
      quotient_out  <= 16'd0;
      remainder_out <= 8'd0;
      div_by_zero   <= 1'b0;
    end else if (accept) begin
      if (divisor == 8'd0) begin
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
        work_q      <= dividend;
        work_r      <= 8'd0;
        dvsr        <= divisor;
        iter        <= 4'd15;
      end
    end else if (step) begin
      work_q <= next_q;
      work_r <= next_r;
      if (iter == 4'd0) begin
        quotient_out  <= next_q;
        remainder_out <= next_r;
      end else begin
        iter <= iter - 4'd1;
      end
    end
  end

  assign done_flag = (state == CALC_DONE);
  assign err_flag  = (state == ERR);
  assign busy      = (state == CALC);
  assign state_out = state;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_16x8.sv
// Self-checking bench for seq_divider_16x8 using an expected-result queue.
`default_nettype none

module tb_seq_divider_16x8;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient_out;
  logic [7:0]  remainder_out;
  logic        done_flag;
  logic        err_flag;
  logic        div_by_zero;
  logic        busy;
  logic [2:0]  state_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_seen = 0;
  logic [23:0] exp_q[$];
  logic [15:0] last_q = 16'd0;
  logic [7:0]  last_r = 8'd0;

  seq_divider_16x8 dut (
    .clk           (clk),
    .reset_a       (reset_a),
    .start         (start),
    .dividend      (dividend),
    .divisor       (divisor),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .done_flag     (done_flag),
    .err_flag      (err_flag),
    .div_by_zero   (div_by_zero),
    .busy          (busy),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_flag) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; a non-zero divisor queues the model result.
  task automatic start_div(input logic [15:0] a, input logic [7:0] b, input bit expect_result);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (b != 8'd0 && expect_result) exp_q.push_back({a / {8'd0, b}, 8'(a % {8'd0, b})});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int          cnt;
    logic [23:0] e;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!done_flag && cnt < 40);
    check({tag, " latency"}, cnt, 16);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (done_flag) begin
        check({tag, " quotient"}, quotient_out, e[23:8]);
        check({tag, " remainder"}, remainder_out, e[7:0]);
        check({tag, " state"}, state_out, 3'b100);
        check({tag, " busy off"}, busy, 1'b0);
        last_q = e[23:8];
        last_r = e[7:0];
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    tick();
    check({tag, " done pulse width"}, done_flag, 1'b0);
    check({tag, " back to idle"}, state_out, 3'b000);
  endtask

  initial begin
    int d0;
    reset_a  = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 8'd0;
    tick();
    tick();
    reset_a = 1'b0;
    check("reset quotient", quotient_out, 0);
    check("reset remainder", remainder_out, 0);
    check("reset flags", {done_flag, err_flag, div_by_zero, busy}, 4'b0000);
    check("reset state", state_out, 3'b000);
    tick();
    check("idle hold", state_out, 3'b000);

    // 203/7 inverts the multiplier's 29x7
    start_div(16'd203, 8'd7, 1);
    check("203/7 busy", busy, 1'b1);
    check("203/7 calc state", state_out, 3'b010);
    wait_done("203/7");
    check("203/7 literal quotient", quotient_out, 29);
    expect_idle("203/7");

    start_div(16'd65535, 8'd255, 1);
    wait_done("65535/255");
    expect_idle("65535/255");
    start_div(16'd65535, 8'd1, 1);
    wait_done("65535/1");
    start_div(16'd3, 8'd200, 1);
    wait_done("3/200");
    check("3/200 literal remainder", remainder_out, 3);
    expect_idle("3/200");
    for (int i = 0; i < 3; i++) begin
      start_div(16'($urandom), 8'($urandom_range(1, 255)), 1);
      wait_done("random");
    end
    expect_idle("random");

    // divide by zero
    start_div(16'd1234, 8'd0, 0);
    check("div0 state", state_out, 3'b101);
    check("div0 err_flag", err_flag, 1'b1);
    check("div0 sticky", div_by_zero, 1'b1);
    check("div0 quotient kept", quotient_out, last_q);
    check("div0 remainder kept", remainder_out, last_r);
    tick();
    check("div0 stays in err", state_out, 3'b101);
    start_div(16'd1000, 8'd7, 1);
    check("div0 cleared", div_by_zero, 1'b0);
    wait_done("1000/7");
    check("1000/7 literal", {quotient_out, remainder_out}, {16'd142, 8'd6});
    expect_idle("1000/7");

    // abort on the 5th CALC cycle
    d0 = done_seen;
    start_div(16'd203, 8'd7, 0);
    repeat (4) tick();
    check("abort still busy", busy, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort state", state_out, 3'b101);
    check("abort err_flag", err_flag, 1'b1);
    check("abort no div0", div_by_zero, 1'b0);
    check("abort quotient kept", quotient_out, last_q);
    check("abort remainder kept", remainder_out, last_r);
    repeat (20) tick();
    check("abort no done", done_seen, d0);

    // reset on the 8th CALC cycle
    start_div(16'd4321, 8'd13, 0);
    repeat (7) tick();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check("midreset outputs", {quotient_out, remainder_out}, 24'd0);
    check("midreset flags", {done_flag, err_flag, div_by_zero, busy}, 4'b0000);
    check("midreset state", state_out, 3'b000);
    repeat (20) tick();
    check("midreset no done", done_seen, d0);
    check("midreset idle", state_out, 3'b000);

    // back-to-back with start held through CALC_DONE
    start_div(16'd203, 8'd7, 1);
    wait_done("b2b first");
    start_div(16'd500, 8'd9, 1);
    check("b2b restart state", state_out, 3'b010);
    wait_done("b2b second");
    check("500/9 literal", {quotient_out, remainder_out}, {16'd55, 8'd5});
    expect_idle("b2b");

    check("queue drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
